imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Instruction-memory responder that sits on the memory side of the fetch unit's request interface. It accepts one 64-bit-word read per valid/ready handshake and returns the word on rdata/rvalid a fixed number of cycles later, with no response backpressure. A single-port backing array is preloaded through a loader write port. A write steals the port for that cycle, so it is the only structural stall.

Parameters:
Xlen, 64, data/address width; must be 64 (two 32-bit instructions per word)
DepthLog2, 10, log2 of number of 64-bit words in the array
Latency, 1, cycles from accepted request to rvalid; range 1..4; fetch requires 1
LfsrSeed, 16'hACE1, seed of stall LFSR (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mem_valid_i  in  1  read request valid
mem_ready_o  out  1  responder can accept a request this cycle
mem_addr_i  in  Xlen  byte address of request
mem_rdata_o  out  Xlen  64-bit word read
mem_rvalid_o  out  1  mem_rdata_o valid this cycle, single-cycle pulse per request
ld_valid_i  in  1  loader write strobe
ld_addr_i  in  Xlen  loader byte address
ld_data_i  in  Xlen  loader write data
ld_strb_i  in  Xlen/8  byte enables for loader write

Behaviour:
- Reset (async assert, sync release): mem_ready_o=0, mem_rvalid_o=0, mem_rdata_o=0, response pipeline cleared, LFSR=LfsrSeed. Array contents are not reset.
- Index = addr[DepthLog2+2:3]. Bits [2:0] are ignored and upper bits wrap/alias; no error response.
- mem_ready_o = !ld_valid_i (plus the stall term under the optional feature). It is combinational from ld_valid_i and is 0 while in reset.
- Accept: mem_valid_i && mem_ready_o at edge N. The array is read and the word travels a Latency-deep shift register of {valid,data}.
- Response: mem_rvalid_o=1 with data on cycle N+Latency, exactly once per accept and in request order.
- Back-to-back: accepts are allowed every cycle. Up to Latency requests are in flight, and rvalid streams at full rate.
- Between responses mem_rdata_o holds its last value; it is not cleared.
- Loader write at edge with ld_valid_i: the bytes selected by ld_strb_i are written. No read is accepted that cycle.
- Write then read of the same word on the next cycle returns the new data.
- A request dropped before handshake (mem_valid_i falls while ready=0) generates no response. The address may change while not accepted.
- Control hazard from fetch needs no special handling: every accepted request is answered, and the initiator discards unwanted data.
- Reset mid-flight: all in-flight responses are dropped. No rvalid appears after reset release until a new accept.

Optional Feature:
- Macro IMEM_RANDOM_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset. mem_ready_o is additionally forced 0 when lfsr[1:0]==2'b00, about 25% of cycles. This is used to stress the fetch hazard/refetch paths. Responses are unaffected.
- Undefined: no LFSR logic; ready depends only on ld_valid_i.

Test Plan:
- Preload word 0 = 64'h0000_0013_0010_0093 and word 1 = 64'h0020_0113_0030_0193; req addr 0x0 then 0x8 on consecutive cycles (Latency=1) -> rvalid on the next two cycles with those words in order, ready stays 1.
- Req addr 0x4 -> same word as 0x0 returned (bits [2:0] ignored); req addr (1<<(DepthLog2+3)) -> aliases to word 0.
- ld_valid_i=1 with mem_valid_i=1 same cycle -> mem_ready_o=0, no response for that cycle; ld_strb_i=8'h0F, data 64'hFFFF_FFFF_FFFF_FFFF onto word 64'h1111_2222_3333_4444 -> read returns 64'h1111_2222_FFFF_FFFF.
- Latency=3, four back-to-back requests, addr 0x0,0x8,0x10,0x18 -> rvalid cycles N+3..N+6 with matching data, no gaps.
- Assert rst_ni=0 asynchronously mid-cycle with two requests in flight -> rvalid/ready drop immediately; after release, no stale rvalid; a new request returns correct data.
- IMEM_RANDOM_STALL_EN defined, 1000 random requests -> ready deasserts in about 25% of cycles, every accepted request answered exactly once in order, none answered for unaccepted cycles.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency 64-bit word reads, loader write port.
// Optional IMEM_RANDOM_STALL_EN adds LFSR-driven ready stalls.
module imem_responder #(
  parameter int          Xlen      = 64,
  parameter int          DepthLog2 = 10,
  parameter int          Latency   = 1,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [Xlen-1:0]   mem_addr_i,
  output logic [Xlen-1:0]   mem_rdata_o,
  output logic              mem_rvalid_o,
  input  logic              ld_valid_i,
  input  logic [Xlen-1:0]   ld_addr_i,
  input  logic [Xlen-1:0]   ld_data_i,
  input  logic [Xlen/8-1:0] ld_strb_i
);

  localparam int Depth = 1 << DepthLog2;
  localparam int Nb    = Xlen / 8;

  logic [Xlen-1:0]      mem_q [Depth];
  logic [DepthLog2-1:0] ridx;
  logic [DepthLog2-1:0] widx;
  logic                 accept;
  logic                 stall;
  logic [Latency-1:0]   vld_q;
  logic [Latency-1:0]   vld_d;
  logic [Xlen-1:0]      dat_q [Latency];
  logic [Xlen-1:0]      dat_d [Latency];
  logic                 unused_addr;

  assign ridx = mem_addr_i[DepthLog2+2:3];
  assign widx = ld_addr_i[DepthLog2+2:3];
  assign unused_addr = ^{mem_addr_i[Xlen-1:DepthLog2+3], mem_addr_i[2:0],
                         ld_addr_i[Xlen-1:DepthLog2+3], ld_addr_i[2:0]};

`ifdef IMEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^LfsrSeed;
  assign stall = 1'b0;
`endif

  // Loader owns the single array port in its cycle, so reads are refused.
  assign mem_ready_o = rst_ni & ~ld_valid_i & ~stall;
  assign accept      = mem_valid_i & mem_ready_o;

  always_ff @(posedge clk_i) begin
    if (ld_valid_i) begin
      for (int b = 0; b < Nb; b++) begin
        if (ld_strb_i[b]) mem_q[widx][b*8 +: 8] <= ld_data_i[b*8 +: 8];
      end
    end
  end

  // Data stages only load behind a valid so the output holds its last word.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = accept;
    if (accept) dat_d[0] = mem_q[ridx];
    for (int i = 1; i < Latency; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < Latency; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign mem_rvalid_o = vld_q[Latency-1];
  assign mem_rdata_o  = dat_q[Latency-1];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a Latency=1 and a Latency=3
// instance share all inputs; each has its own expected-response queue.
module tb_imem_responder;

  typedef struct {
    logic [63:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_addr = '0;
  logic        ld_valid = 1'b0;
  logic [63:0] ld_addr = '0;
  logic [63:0] ld_data = '0;
  logic [7:0]  ld_strb = '0;

  logic        ready1, rvalid1;
  logic [63:0] rdata1;
  logic        ready3, rvalid3;
  logic [63:0] rdata3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q1[$];
  exp_t q3[$];
  logic [63:0] model [1024];

  imem_responder #(.Latency(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_valid_i(mem_valid), .mem_ready_o(ready1),
    .mem_addr_i(mem_addr), .mem_rdata_o(rdata1),
    .mem_rvalid_o(rvalid1),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_strb_i(ld_strb)
  );

  imem_responder #(.Latency(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_valid_i(mem_valid), .mem_ready_o(ready3),
    .mem_addr_i(mem_addr), .mem_rdata_o(rdata3),
    .mem_rvalid_o(rvalid3),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_strb_i(ld_strb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [63:0] a);
    return int'(a[12:3]);
  endfunction

  always @(negedge clk) begin
    if (rvalid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp_l1_unexpected got=%h cyc=%0d", rdata1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (rdata1 !== e.d || cyc !== e.c) begin
          errors++;
          $display("FAIL rsp_l1 got=%h@%0d want=%h@%0d",
                   rdata1, cyc, e.d, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rsp_l3_unexpected got=%h cyc=%0d", rdata3, cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (rdata3 !== e.d || cyc !== e.c) begin
          errors++;
          $display("FAIL rsp_l3 got=%h@%0d want=%h@%0d",
                   rdata3, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    mem_valid = 1'b0;
    ld_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_data   = d;
    ld_strb   = s;
    for (int b = 0; b < 8; b++)
      if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
    @(negedge clk);
  endtask

  // Holds the request until accepted, like a fetch unit would.
  task automatic req(input logic [63:0] a, input logic [63:0] e);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      ld_valid  = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = a;
      @(negedge clk);
      if (ready1) q1.push_back('{e, cyc + 1});
      if (ready3) q3.push_back('{e, cyc + 3});
      if (ready1) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL req_timeout addr=%h ready=0 want=1", a);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ready1, rvalid1, ready3, rvalid3} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0000",
               {ready1, rvalid1, ready3, rvalid3});
    end
    checks++;
    if (rdata1 !== 64'h0 || rdata3 !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h/%h want=0", rdata1, rdata3);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
`ifndef IMEM_RANDOM_STALL_EN
    checks++;
    if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b%b want=11", ready1, ready3);
    end
`endif
  endtask

  task automatic test_basic();
    load(64'h0, 64'h0000_0013_0010_0093, 8'hFF);
    load(64'h8, 64'h0020_0113_0030_0193, 8'hFF);
    load(64'h10, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    load(64'h18, 64'hCAFE_F00D_1234_5678, 8'hFF);
    req(64'h0, 64'h0000_0013_0010_0093);
    req(64'h8, 64'h0020_0113_0030_0193);
    idle();
    idle();
    checks++;
    if (rvalid1 !== 1'b0 || rdata1 !== 64'h0020_0113_0030_0193) begin
      errors++;
      $display("FAIL rdata_hold got=%b/%h want=0/%h",
               rvalid1, rdata1, 64'h0020_0113_0030_0193);
    end
    repeat (3) idle();
  endtask

  task automatic test_alias();
    req(64'h4, 64'h0000_0013_0010_0093);
    req(64'h2000, 64'h0000_0013_0010_0093);
    req(64'hF000_0000_0000_200F, 64'h0020_0113_0030_0193);
    repeat (4) idle();
  endtask

  task automatic test_loader();
    @(posedge clk); #1;
    ld_valid  = 1'b1;
    ld_addr   = 64'h28;
    ld_data   = 64'h1111_2222_3333_4444;
    ld_strb   = 8'hFF;
    mem_valid = 1'b1;
    mem_addr  = 64'h0;
    model[5]  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0 || ready3 !== 1'b0) begin
      errors++;
      $display("FAIL ld_blocks_ready got=%b%b want=00", ready1, ready3);
    end
    load(64'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    req(64'h28, 64'h1111_2222_FFFF_FFFF);
    repeat (4) idle();
  endtask

  task automatic test_back_to_back();
    req(64'h0, model[0]);
    req(64'h8, model[1]);
    req(64'h10, model[2]);
    req(64'h18, model[3]);
    repeat (4) idle();
    checks++;
    if (rvalid3 !== 1'b0 || rdata3 !== model[3]) begin
      errors++;
      $display("FAIL l3_hold got=%b/%h want=0/%h", rvalid3, rdata3, model[3]);
    end
  endtask

  task automatic test_reset_midflight();
    req(64'h10, model[2]);
    req(64'h18, model[3]);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready1, rvalid1, ready3, rvalid3} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_ctrl got=%b want=0000",
               {ready1, rvalid1, ready3, rvalid3});
    end
    checks++;
    if (rdata1 !== 64'h0) begin
      errors++;
      $display("FAIL midreset_rdata got=%h want=0", rdata1);
    end
    q1.delete();
    q3.delete();
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    repeat (5) idle();
    req(64'h8, model[1]);
    repeat (4) idle();
  endtask

  task automatic test_random();
    int stalls;
    int w;
    logic [63:0] a;
    stalls = 0;
    for (int i = 0; i < 16; i++)
      load(64'(i) << 3, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 1000; i++) begin
      w = int'($urandom_range(15, 0));
      a = {32'($urandom), 19'($urandom), 10'(w), 3'($urandom)};
      @(posedge clk); #1;
      ld_valid  = 1'b0;
      mem_valid = ($urandom_range(3, 0) != 0);
      mem_addr  = a;
      @(negedge clk);
      if (!ready1) stalls++;
      if (mem_valid && ready1) q1.push_back('{model[w], cyc + 1});
      if (mem_valid && ready3) q3.push_back('{model[w], cyc + 3});
    end
    repeat (5) idle();
    checks++;
`ifdef IMEM_RANDOM_STALL_EN
    if (stalls < 150 || stalls > 350) begin
      errors++;
      $display("FAIL stall_rate got=%0d want=150..350", stalls);
    end
`else
    if (stalls != 0) begin
      errors++;
      $display("FAIL stall_rate got=%0d want=0", stalls);
    end
`endif
  endtask

  task automatic test_drain();
    repeat (6) idle();
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp got=%0d/%0d want=0/0",
               q1.size(), q3.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_loader();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
